// File: rtl/sram_1rw_ctrl_if.sv
// Request/response bus of the single-port SRAM controller.
// Master drives requests and rsp_ready; slave is the controller.
interface sram_1rw_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 33,
  parameter int NUM_WMASKS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic                  req_spare_wen;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_wmask,
    output req_spare_wen,
    output req_addr,
    output req_wdata,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_wmask,
    input  req_spare_wen,
    input  req_addr,
    input  req_wdata,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/sram_1rw_ctrl.sv
// Single-port SRAM controller: registered SRAM pins, 2-stage
// read tracking and a credit-guarded response FIFO.
module sram_1rw_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 33,
  parameter int NUM_WMASKS = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  sram_1rw_ctrl_if.slave        bus,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic                  spare_wen0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef logic [PW-1:0]         ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [SW-1:0]         sum_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic                  spare_q, spare_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  data_t                 din_q, din_d;

  logic rd1_q, rd1_d;
  logic rd2_q, rd2_d;
  logic rdy_q, rdy_d;

  cnt_t  cnt_q, cnt_d;
  ptr_t  wptr_q, wptr_d;
  ptr_t  rptr_q, rptr_d;
  data_t mem_q [RSP_DEPTH];

  logic accept;
  logic acc_rd;
  logic push;
  logic pop;
  logic nempty;
  logic full;
  sum_t credit;

  assign accept = bus.req_valid & rdy_q;
  assign acc_rd = accept & ~bus.req_we;
  assign push   = rd2_q;
  assign nempty = (cnt_q != '0);
  assign full   = (cnt_q == cnt_t'(RSP_DEPTH));
  assign pop    = nempty & bus.rsp_ready;

  always_comb begin
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = '0;
    spare_d = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    if (accept) begin
      csb_d  = 1'b0;
      web_d  = ~bus.req_we;
      addr_d = bus.req_addr;
      din_d  = bus.req_wdata;
      if (bus.req_we) begin
        wmask_d = bus.req_wmask;
        spare_d = bus.req_spare_wen;
      end
    end
  end

  always_comb begin
    rd1_d  = acc_rd;
    rd2_d  = rd1_q;
    wptr_d = push ? ptr_t'(wptr_q + 1'b1) : wptr_q;
    rptr_d = pop  ? ptr_t'(rptr_q + 1'b1) : rptr_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      (push && !pop): cnt_d = cnt_t'(cnt_q + 1'b1);
      (pop && !push): cnt_d = cnt_t'(cnt_q - 1'b1);
      default:        cnt_d = cnt_q;
    endcase
    // Credit counts every read that will still need a FIFO slot
    credit = sum_t'(cnt_d) + sum_t'(rd1_d) + sum_t'(rd2_d);
    rdy_d  = (credit < sum_t'(RSP_DEPTH));
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      spare_q <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      spare_q <= spare_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      rd1_q  <= 1'b0;
      rd2_q  <= 1'b0;
      rdy_q  <= 1'b0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      rdy_q  <= rdy_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wptr_q] <= dout0;
    end
  end

  assign csb0       = csb_q;
  assign web0       = web_q;
  assign wmask0     = wmask_q;
  assign spare_wen0 = spare_q;
  assign addr0      = addr_q;
  assign din0       = din_q;

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = nempty;
  assign bus.rsp_rdata = nempty ? mem_q[rptr_q] : '0;

`ifndef SYNTHESIS
  a_no_ovf: assert property (
    @(posedge clk0) disable iff (rst0)
    !(push && !pop && full)
  ) else $error("rsp fifo overflow");
`endif

endmodule

// File: doc/sram_1rw_ctrl.md
SRAM_1RW_CTRL -- requirements
Module: sram_1rw_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: SRAM word address width.
REQ-002 Parameter DATA_WIDTH, default 33: data width; bits [31:0] are byte-masked, bit 32 is the spare bit.
REQ-003 Parameter NUM_WMASKS, default 4: byte write-enable count.
REQ-004 Parameter RSP_DEPTH, default 4: response FIFO depth, power of two, at least 2.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; the ports are listed below.
REQ-006 clk0  in  1  clock; all registers use the rising edge.
REQ-007 rst0  in  1  asynchronous active-high reset.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  request can be accepted.
REQ-010 req_we  in  1  1 = write, 0 = read.
REQ-011 req_wmask  in  NUM_WMASKS  byte enables for a write.
REQ-012 req_spare_wen  in  1  spare-bit enable for a write.
REQ-013 req_addr  in  ADDR_WIDTH  word address.
REQ-014 req_wdata  in  DATA_WIDTH  write data.
REQ-015 rsp_valid  out  1  read data available.
REQ-016 rsp_ready  in  1  consumer accepts read data.
REQ-017 rsp_rdata  out  DATA_WIDTH  read data.
REQ-018 csb0, web0  out  1 each  SRAM active-low chip select and write enable.
REQ-019 wmask0  out  NUM_WMASKS  SRAM write mask.
REQ-020 spare_wen0  out  1  SRAM spare-bit write enable.
REQ-021 addr0  out  ADDR_WIDTH  SRAM address.
REQ-022 din0  out  DATA_WIDTH  SRAM write data.
REQ-023 dout0  in  DATA_WIDTH  SRAM read data.

Function
REQ-024 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-025 SRAM-side outputs SHALL be registered and SHALL be updated on the accepting edge E, with these values:
- csb0 = 0, web0 = !req_we, addr0 = req_addr, din0 = req_wdata;
- for a write, wmask0 = req_wmask and spare_wen0 = req_spare_wen;
- for a read, wmask0 = 0 and spare_wen0 = 0.
REQ-026 On an edge with no acceptance, csb0, web0, wmask0 and spare_wen0 SHALL return to 1, 1, 0 and 0; addr0 and din0 SHALL hold their values.
REQ-027 The SRAM samples its inputs at edge E+1; the block SHALL capture dout0 into the response FIFO at edge E+2 for every accepted read.
REQ-028 A 2-stage read-tracking shift register SHALL mark which edges require a dout0 capture.
REQ-029 Read latency: with the FIFO empty and rsp_ready = 1, rsp_valid SHALL be 1 in the cycle following edge E+2.
REQ-030 Throughput: one request per cycle, with reads and writes interleaved in any mix, and no bubbles while credit remains.
REQ-031 Request order SHALL be preserved: a read following a write to the same address returns the written bytes.
REQ-032 Response FIFO behaviour:
- rsp_rdata SHALL be the FIFO head;
- rsp_valid SHALL be 1 whenever the FIFO is non-empty;
- the FIFO pops on rsp_valid && rsp_ready.
REQ-033 Credit: req_ready SHALL be registered and equal to 1 iff (reads in flight + FIFO occupancy + reads accepted this edge - pops this edge) < RSP_DEPTH.
REQ-034 req_ready SHALL NOT depend combinationally on req_valid, req_we or rsp_ready.
REQ-035 Writes SHALL consume no credit but SHALL be blocked whenever req_ready = 0.
REQ-036 When a FIFO push and a pop fall on the same edge, occupancy SHALL be unchanged; the FIFO SHALL never overflow, and this SHALL be asserted in simulation.
REQ-037 The FIFO read and write pointers SHALL wrap modulo RSP_DEPTH.
REQ-038 A write with wmask0 = 0 and spare_wen0 = 0 SHALL still be issued (csb0 = 0, web0 = 0) and SHALL not be dropped.

Reset
REQ-039 While rst0 is high, the block SHALL immediately and asynchronously drive:
- csb0 = 1, web0 = 1, wmask0 = 0, spare_wen0 = 0;
- addr0 = 0, din0 = 0;
- rsp_valid = 0, rsp_rdata = 0, req_ready = 0.
REQ-040 Reset mid-operation SHALL discard all in-flight reads and FIFO contents; no response for them SHALL appear after reset.
REQ-041 req_ready SHALL become 1 on the first rising edge after rst0 falls.

Verification
REQ-042 Write then read: write addr 0x005, data 0x1_DEADBEEF, wmask 4'hF, spare 1; then read 0x005 -> rsp_rdata = 0x1_DEADBEEF, rsp_valid 2 edges after the read is accepted.
REQ-043 Byte mask: write 0x0_11223344 to 0x010 with full mask; write 0x0_AABBCCDD with wmask 4'b0101, spare 0; read 0x010 -> 0x0_11BB33DD.
REQ-044 Backpressure: rsp_ready = 0, issue 6 back-to-back reads -> exactly 4 accepted and req_ready = 0; then rsp_ready = 1 -> 4 responses in order, after which the remaining 2 reads are accepted.
REQ-045 Streaming: 16 consecutive reads of 0x000-0x00F with rsp_ready = 1 -> req_ready stays 1, 16 in-order responses, no gaps.
REQ-046 Reset mid-stream: assert rst0 with 2 reads in flight and 1 buffered -> csb0 = 1 and rsp_valid = 0 at once; after release no stale response and req_ready = 1 one edge later.
REQ-047 Idle check: with no requests, csb0 = 1, web0 = 1 and wmask0 = 0 on every cycle.
